// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler that shares one serial pattern matcher across NCH channels.
// Optional `SEQ_DET_SCHED_CH_MASK_EN adds a ch_mask input that excludes channels from arbitration.
module seq_det_sched #(
    parameter int              NCH     = 4,
    parameter int              PLEN    = 5,
    parameter logic [PLEN-1:0] PATTERN = 5'b00100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH-1:0]         in_bit,
    output logic [NCH-1:0]         in_ready,
`ifdef SEQ_DET_SCHED_CH_MASK_EN
    input  logic [NCH-1:0]         ch_mask,
`endif
    input  logic                   cfg_we,
    input  logic [PLEN-1:0]        cfg_pattern,
    output logic                   busy,
    output logic                   det_valid,
    output logic [$clog2(NCH)-1:0] det_ch,
    output logic [15:0]            match_cnt,
    output logic [1:0]             dbg_state
);
    localparam int CW = $clog2(NCH);
    localparam int FW = $clog2(PLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [PLEN-1:0] r_pattern;
    logic [PLEN-1:0] r_hist [NCH];
    logic [FW-1:0]   r_fill [NCH];
    logic [CW-1:0]   r_ptr;
    logic            r_det_valid;
    logic [CW-1:0]   r_det_ch;
    logic [15:0]     r_match_cnt;

    logic [NCH-1:0]  w_req;
    logic [NCH-1:0]  w_rot;
    logic [CW:0]     w_sum;
    logic            w_xfer;
    logic [CW-1:0]   w_gidx;
    logic [NCH-1:0]  w_grant;
    logic [PLEN-1:0] w_new_hist;
    logic            w_match;

`ifdef SEQ_DET_SCHED_CH_MASK_EN
    assign w_req = in_valid & ~ch_mask;
`else
    assign w_req = in_valid;
`endif

    // Rotate requests so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        w_rot  = NCH'({w_req, w_req} >> r_ptr);
        w_xfer = 1'b0;
        w_sum  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_xfer && w_rot[k]) begin
                w_xfer = 1'b1;
                w_sum  = {1'b0, r_ptr} + (CW+1)'(k);
            end
        end
        if (w_sum >= (CW+1)'(NCH)) begin
            w_sum = w_sum - (CW+1)'(NCH);
        end
        w_gidx = CW'(w_sum);
        if (r_state != S_RUN) begin
            w_xfer = 1'b0;
        end
        w_grant = w_xfer ? (NCH'(1) << w_gidx) : '0;
    end

    assign w_new_hist = {r_hist[w_gidx][PLEN-2:0], in_bit[w_gidx]};
    assign w_match    = w_xfer && (r_fill[w_gidx] >= FW'(PLEN - 1)) && (w_new_hist == r_pattern);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pattern   <= PATTERN;
            r_ptr       <= '0;
            r_det_valid <= 1'b0;
            r_det_ch    <= '0;
            r_match_cnt <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_hist[k] <= '0;
                r_fill[k] <= '0;
            end
        end else begin
            r_det_valid <= w_match;
            if (w_match) begin
                r_det_ch <= w_gidx;
                if (r_match_cnt != 16'hFFFF) begin
                    r_match_cnt <= r_match_cnt + 16'd1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_we) begin
                        r_pattern <= cfg_pattern;
                    end
                    // Every run starts from empty context so no pattern spans a stop.
                    if (enable) begin
                        r_state     <= S_RUN;
                        r_ptr       <= '0;
                        r_match_cnt <= '0;
                        for (int k = 0; k < NCH; k++) begin
                            r_hist[k] <= '0;
                            r_fill[k] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_hist[w_gidx] <= w_new_hist;
                        if (r_fill[w_gidx] != FW'(PLEN)) begin
                            r_fill[w_gidx] <= r_fill[w_gidx] + FW'(1);
                        end
                        r_ptr <= (w_gidx == CW'(NCH - 1)) ? '0 : w_gidx + CW'(1);
                    end
                    if (!enable) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = w_grant;
    assign busy      = (r_state != S_IDLE);
    assign det_valid = r_det_valid;
    assign det_ch    = r_det_ch;
    assign match_cnt = r_match_cnt;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transfer-log model of the scheduler and matcher.
module tb_seq_det_sched;
    localparam int NCH  = 4;
    localparam int PLEN = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [NCH-1:0]  in_valid = '0;
    logic [NCH-1:0]  in_bit = '0;
    logic [NCH-1:0]  in_ready;
    logic            cfg_we = 1'b0;
    logic [PLEN-1:0] cfg_pattern = '0;
    logic            busy;
    logic            det_valid;
    logic [1:0]      det_ch;
    logic [15:0]     match_cnt;
    logic [1:0]      dbg_state;
`ifdef SEQ_DET_SCHED_CH_MASK_EN
    logic [NCH-1:0]  ch_mask = '0;
`endif

    seq_det_sched #(.NCH(NCH), .PLEN(PLEN), .PATTERN(5'b00100)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
`ifdef SEQ_DET_SCHED_CH_MASK_EN
        .ch_mask(ch_mask),
`endif
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .busy(busy),
        .det_valid(det_valid), .det_ch(det_ch), .match_cnt(match_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit lit_on = 1'b0;
    logic [1:0] exp_q[$];

    // Model: mode 0 idle, 1 run, 2 drain; m_log holds every accepted bit as ch*2+bit.
    int m_mode = 0;
    logic [PLEN-1:0] m_pat = 5'b00100;
    int m_ptr = 0;
    int m_log[$];
    bit m_det = 1'b0;
    int m_det_ch = 0;
    int m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The newest PLEN bits of channel g, newest first, must equal pattern LSB upward.
    function automatic bit tail_matches(input int g);
        int got = 0;
        for (int i = m_log.size() - 1; i >= 0 && got < PLEN; i--) begin
            if (m_log[i] / 2 == g) begin
                if ((m_log[i] % 2) != ((int'(m_pat) >> got) & 1)) return 1'b0;
                got++;
            end
        end
        return got == PLEN;
    endfunction

    initial forever begin
        logic [NCH-1:0] req;
        logic [NCH-1:0] exp_ready;
        int g;
        @(negedge clk);
        if (!rst) begin
            m_mode = 0; m_pat = 5'b00100; m_ptr = 0; m_log.delete();
            m_det = 1'b0; m_det_ch = 0; m_cnt = 0;
            check("rst_in_ready", in_ready, 0);
            check("rst_det_valid", det_valid, 0);
            check("rst_det_ch", det_ch, 0);
            check("rst_match_cnt", match_cnt, 0);
            check("rst_busy", busy, 0);
        end else begin
            req = in_valid;
`ifdef SEQ_DET_SCHED_CH_MASK_EN
            req = req & ~ch_mask;
`endif
            g = -1;
            exp_ready = '0;
            if (m_mode == 1) begin
                for (int k = 0; k < NCH; k++) begin
                    if (g < 0 && req[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            check("in_ready", in_ready, exp_ready);
            check("busy", busy, (m_mode != 0));
            check("det_valid", det_valid, m_det);
            if (m_det) check("det_ch", det_ch, m_det_ch);
            check("match_cnt", match_cnt, m_cnt);
            if (lit_on && det_valid) begin
                if (exp_q.size() > 0) check("det_ch_lit", det_ch, exp_q.pop_front());
                else begin
                    n_cmp++; n_err++;
                    $display("FAIL det_lit: unexpected det on ch %0d at %0t", det_ch, $time);
                end
            end
            m_det = 1'b0;
            case (m_mode)
                0: begin
                    if (cfg_we) m_pat = cfg_pattern;
                    if (enable) begin
                        m_mode = 1; m_ptr = 0; m_cnt = 0; m_log.delete();
                    end
                end
                1: begin
                    if (g >= 0) begin
                        m_log.push_back(g * 2 + int'(in_bit[g]));
                        m_ptr = (g + 1) % NCH;
                        if (tail_matches(g)) begin
                            m_det = 1'b1; m_det_ch = g;
                            if (m_cnt < 65535) m_cnt++;
                        end
                    end
                    if (!enable) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
    end

    task automatic push_bit(input int ch, input logic b);
        bit ok = 1'b0;
        in_valid[ch] = 1'b1;
        in_bit[ch] = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready[ch]) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL grant_timeout: ch %0d never granted at %0t", ch, $time);
        end
        @(posedge clk); #1;
        in_valid[ch] = 1'b0;
    endtask

    task automatic send_seq(input int ch, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) push_bit(ch, bits[i]);
    endtask

    task automatic start_run();
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic stop_run();
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); #1 check("drain_busy", busy, 1);
        @(posedge clk); #1 check("idle_busy", busy, 0);
    endtask

    task automatic write_cfg(input logic [PLEN-1:0] p);
        cfg_pattern = p; cfg_we = 1'b1;
        @(posedge clk); #1 cfg_we = 1'b0;
    endtask

    task automatic settle_and_count(input string name, input int cnt);
        repeat (2) @(posedge clk);
        #1 check(name, match_cnt, cnt);
        check("det_lit_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [NCH-1:0] gsamp;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        lit_on = 1'b1;

        start_run();
        exp_q.push_back(2'd0);
        send_seq(0, 16'b00100, 5);
        check("single_det_now", det_valid, 1);
        settle_and_count("single_cnt", 1);

        stop_run(); start_run();
        exp_q.push_back(2'd2); exp_q.push_back(2'd2);
        send_seq(2, 16'b00100100, 8);
        settle_and_count("overlap_cnt", 2);

        stop_run(); start_run();
        for (int c = 0; c < NCH; c++) exp_q.push_back(2'(c));
        fork
            send_seq(0, 16'b00100, 5);
            send_seq(1, 16'b00100, 5);
            send_seq(2, 16'b00100, 5);
            send_seq(3, 16'b00100, 5);
        join
        settle_and_count("fair_cnt", 4);

        stop_run();
        write_cfg(5'b11011);
        start_run();
        exp_q.push_back(2'd1);
        send_seq(1, 16'b11011, 5);
        write_cfg(5'b00000);
        send_seq(1, 16'b00000, 5);
        exp_q.push_back(2'd0);
        send_seq(0, 16'b11011, 5);
        settle_and_count("cfg_cnt", 2);

        stop_run();
        write_cfg(5'b00100);
        start_run();
        send_seq(0, 16'b001, 3);
        stop_run(); start_run();
        send_seq(0, 16'b00, 2);
        exp_q.push_back(2'd0);
        send_seq(0, 16'b100, 3);
        settle_and_count("restart_cnt", 1);

        lit_on = 1'b0;
        stop_run(); start_run();
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk) gsamp = in_ready;
            @(posedge clk); #1;
            for (int c = 0; c < NCH; c++) begin
                if (!in_valid[c] || gsamp[c]) begin
                    in_valid[c] = ($urandom_range(0, 9) < 6);
                    in_bit[c] = ($urandom_range(0, 2) == 0);
                end
            end
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            cfg_we = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: cfg_pattern = 5'b00100;
                1: cfg_pattern = 5'b00000;
                2: cfg_pattern = 5'b01000;
                default: cfg_pattern = PLEN'($urandom_range(0, 31));
            endcase
        end
        in_valid = '0; cfg_we = 1'b0; enable = 1'b0;
        repeat (4) @(posedge clk);
        #1 lit_on = 1'b1;

        write_cfg(5'b11011);
        start_run();
        send_seq(0, 16'b11011, 5);
        check("rst_pre_det", det_valid, 1);
        in_valid = 4'b0010;
        #1 check("rst_pre_ready", in_ready, 4'b0010);
        #1 rst = 1'b0; enable = 1'b0;
        #1 check("rst_now_det", det_valid, 0);
        check("rst_now_ready", in_ready, 0);
        check("rst_now_cnt", match_cnt, 0);
        check("rst_now_busy", busy, 0);
        in_valid = '0;
        @(posedge clk); #1 rst = 1'b1;
        start_run();
        exp_q.push_back(2'd3);
        send_seq(3, 16'b00100, 5);
        settle_and_count("post_rst_cnt", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
- Shares one pattern-match engine among NCH serial bit-stream channels.
- Round-robin scheduler grants one channel per cycle and keeps a per-channel bit-history context.
- The engine matches that channel's history against a programmable pattern (default 00100, overlapping).
- Reports each match with its channel number and keeps a global match counter. Sits between the per-lane serial receivers and the event/interrupt logic.

Parameters:
NCH, 4, number of requesting channels (2..8)
PLEN, 5, pattern length in bits (2..8)
PATTERN, 5'b00100, reset/default pattern, oldest bit first (MSB = first bit received)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
enable  in  1  1 = run scheduler, 0 = stop
in_valid  in  NCH  per-channel bit available
in_bit  in  NCH  per-channel serial bit
in_ready  out  NCH  one-hot grant; a bit transfers when in_valid[i] & in_ready[i]
cfg_we  in  1  pattern write strobe, honoured only in IDLE
cfg_pattern  in  PLEN  new pattern value
busy  out  1  1 in RUN or DRAIN
det_valid  out  1  one-cycle match pulse
det_ch  out  clog2(NCH)  channel of the match; valid with det_valid
match_cnt  out  16  total matches since entering RUN, saturating

Behaviour:
- Reset (rst=0, async) forces:
  - state = IDLE, pattern register = PATTERN.
  - All histories and fill counters = 0, round-robin pointer = 0.
  - in_ready = 0, det_valid = 0, det_ch = 0, match_cnt = 0, busy = 0.
- FSM IDLE:
  - in_ready = 0.
  - cfg_we=1 loads cfg_pattern at the clock edge.
  - enable=1 moves to RUN next cycle. On that transition all histories, fill counters and match_cnt clear and the pointer goes to 0.
- FSM RUN:
  - in_ready is combinational: grant goes to the first channel with in_valid=1, searching from pointer upward with wrap-around. At most one bit is consumed per cycle.
  - On a transfer from channel g: pointer = g+1 mod NCH; history[g] = {history[g][PLEN-2:0], in_bit[g]}; fill[g] increments, saturating at PLEN.
  - With no request the pointer holds.
  - cfg_we is ignored.
  - enable=0 moves to DRAIN next cycle; a transfer in that same cycle is still accepted.
- FSM DRAIN:
  - Lasts one cycle, in_ready = 0, then IDLE.
  - A det_valid from the last accepted bit still appears in this cycle.
  - Histories are retained until the next IDLE->RUN transition.
- Match rule:
  - A transfer matches when fill[g] (including this bit) >= PLEN and the updated history[g] == pattern.
  - det_valid = 1 and det_ch = g in the cycle after the transfer (latency 1, registered). Otherwise det_valid = 0.
  - Overlap is allowed: history is not cleared on a match. Example: 00100100 gives two matches.
- match_cnt increments on each det_valid pulse and saturates at 16'hFFFF.
- Channels are independent: interleaved bits of different channels never mix histories.
- Simultaneous requests: only the granted channel's in_valid/in_bit are consumed. Other channels must hold their bit until granted.
- enable toggling 1->0->1 clears all context on re-entry to RUN. A pattern never spans a stop.
- Reset mid-RUN: immediate return to the reset state. No det_valid is emitted for a bit in flight.

Optional Feature:
SEQ_DET_SCHED_CH_MASK_EN:
- Defined: adds input ch_mask [NCH]. Channels with ch_mask[i]=1 are never granted and their in_valid is ignored. The mask is sampled every cycle and changes take effect the same cycle. A masked channel's history is frozen, not cleared.
- Undefined: no ch_mask port; all channels are eligible.

Test Plan:
- Single channel: enable=1, channel 0 streams 0,0,1,0,0 -> det_valid=1, det_ch=0 one cycle after the 5th bit; match_cnt=1.
- Overlap: channel 2 streams 0,0,1,0,0,1,0,0 -> two det pulses on bits 5 and 8, det_ch=2; match_cnt=2.
- Fairness: all 4 in_valid held high -> grants cycle 0,1,2,3,0,...; each channel receives 00100 interleaved -> 4 matches, det_ch=0,1,2,3 in order, no cross-channel false match.
- Config: in IDLE write cfg_pattern=5'b11011, then run channel 1 with 1,1,0,1,1 -> match. cfg_we during RUN with 00000 -> pattern unchanged.
- Stop/restart: after 0,0,1 on channel 0, drop enable (DRAIN 1 cycle, busy 1->0), re-enable, send 0,0 -> no match. Then 1,0,0 -> match; match_cnt=1 (counter cleared on restart).
- Async reset mid-RUN with det pending: rst=0 between edges -> det_valid, in_ready, match_cnt all 0 immediately; after release the pattern equals PATTERN.
